// File: rtl/fpu_pkg.sv
// Shared definitions for the FPU Wishbone register bank: register offsets,
// rounding-mode encodings, one-hot operation bit positions and flag order.
package fpu_pkg;

    // Byte offsets of the registers within the 256-byte window.
    localparam logic [7:0] A_OFF      = 8'h00;
    localparam logic [7:0] B_OFF      = 8'h04;
    localparam logic [7:0] C_OFF      = 8'h08;
    localparam logic [7:0] RESULT_OFF = 8'h0C;
    localparam logic [7:0] FLAGS_OFF  = 8'h10;
    localparam logic [7:0] STATUS_OFF = 8'h14;
    localparam logic [7:0] IRQ_EN_OFF = 8'h18;
    localparam logic [7:0] OP_OFF     = 8'h1C;
    localparam logic [7:0] CLEAR_OFF  = 8'h20;
    localparam logic [7:0] RM_OFF     = 8'h24;

    // IEEE-754 rounding modes as seen by the FPU core.
    typedef enum logic [2:0] {
        RM_RNE = 3'd0,
        RM_RTZ = 3'd1,
        RM_RDN = 3'd2,
        RM_RUP = 3'd3,
        RM_RMM = 3'd4
    } round_mode_e;

    // Bit of the OPERATION word that requests an operation (drives valid_o).
    localparam int OP_VALID_BIT = 12;

    // One-hot positions inside op_o.
    localparam int OP_BIT_ADD   = 0;
    localparam int OP_BIT_SUB   = 1;
    localparam int OP_BIT_MUL   = 2;
    localparam int OP_BIT_DIV   = 3;
    localparam int OP_BIT_SQRT  = 4;
    localparam int OP_BIT_FMA   = 5;
    localparam int OP_BIT_MIN   = 6;
    localparam int OP_BIT_MAX   = 7;
    localparam int OP_BIT_CMP   = 8;
    localparam int OP_BIT_F2I   = 9;
    localparam int OP_BIT_I2F   = 10;
    localparam int OP_BIT_CLASS = 11;

    // Exception flag order inside fpu_flags_i / FLAGS: {NV,DZ,OF,UF,NX}.
    localparam int FLAG_NX = 0;
    localparam int FLAG_UF = 1;
    localparam int FLAG_OF = 2;
    localparam int FLAG_DZ = 3;
    localparam int FLAG_NV = 4;

    // STATUS register bit positions.
    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;

    // Replace only the byte lanes enabled in sel.
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                                input logic [31:0] new_val,
                                                input logic [3:0]  sel);
        logic [31:0] res;
        res = old_val;
        for (int i = 0; i < 4; i++) begin
            if (sel[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/fpu_wb_regs.sv
// Wishbone slave register bank in front of the single-precision FPU core.
// Holds operands, rounding mode and operation word, raises valid_o towards
// the core and captures result/flags when the core reports completion.
module fpu_wb_regs
    import fpu_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
    parameter int          OP_W      = 12
) (
    input  logic            wb_clk_i,
    input  logic            rst_l,
    input  logic            wbs_stb_i,
    input  logic            wbs_cyc_i,
    input  logic            wbs_we_i,
    input  logic [3:0]      wbs_sel_i,
    input  logic [31:0]     wbs_adr_i,
    input  logic [31:0]     wbs_dat_i,
    output logic            wbs_ack_o,
    output logic [31:0]     wbs_dat_o,
    output logic [31:0]     a_o,
    output logic [31:0]     b_o,
    output logic [31:0]     c_o,
    output logic [2:0]      round_mode_o,
    output logic [OP_W-1:0] op_o,
    output logic            valid_o,
    input  logic [31:0]     fpu_result_i,
    input  logic [4:0]      fpu_flags_i,
    input  logic            fpu_valid_i,
    output logic            irq_o
);

    // Handshake: a request is cyc & stb & window hit while ack is low. It is
    // sampled on one edge, and ack (with registered read data) is high for
    // exactly the following cycle; a master holding stb through the ack cycle
    // is not re-acknowledged because ack itself masks the request. Writes
    // commit on the edge that raises ack. Addresses outside the window never
    // get an ack.
    logic       hit;
    logic       req;
    logic       wr;
    logic [7:0] off;

    logic [31:0]     a_q, a_d;
    logic [31:0]     b_q, b_d;
    logic [31:0]     c_q, c_d;
    logic [31:0]     result_q, result_d;
    logic [4:0]      flags_q, flags_d;
    logic [OP_W-1:0] op_q, op_d;
    logic            valid_q, valid_d;
    logic            done_q, done_d;
    logic            irq_en_q, irq_en_d;
    logic [2:0]      rm_q, rm_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;

    logic [31:0] rdata;
    logic [31:0] op_word;
    logic [31:0] op_merge;
    logic [31:0] rm_merge;
    logic        unused_bits;

    assign hit = (wbs_adr_i[31:8] == BASE_ADDR[31:8]);
    assign req = wbs_cyc_i & wbs_stb_i & hit & ~ack_q;
    assign wr  = req & wbs_we_i;
    assign off = {wbs_adr_i[7:2], 2'b00};

    // Current OPERATION register contents as software sees them.
    always_comb begin
        op_word               = '0;
        op_word[OP_W-1:0]     = op_q;
        op_word[OP_VALID_BIT] = valid_q;
    end

    // Byte-lane merges for the partially implemented registers.
    assign op_merge = merge_bytes(op_word, wbs_dat_i, wbs_sel_i);
    assign rm_merge = merge_bytes({29'b0, rm_q}, wbs_dat_i, wbs_sel_i);

    // Bits that are intentionally dropped by the decode.
    assign unused_bits = ^{wbs_adr_i[1:0], op_merge[31:OP_VALID_BIT+1], rm_merge[31:3]};

    // Read mux; unmapped and write-only offsets read as zero.
    always_comb begin
        rdata = '0;
        case (off)
            A_OFF:      rdata = a_q;
            B_OFF:      rdata = b_q;
            C_OFF:      rdata = c_q;
            RESULT_OFF: rdata = result_q;
            FLAGS_OFF:  rdata[4:0] = flags_q;
            STATUS_OFF: begin
                rdata[STATUS_DONE_BIT] = done_q;
                rdata[STATUS_BUSY_BIT] = valid_q;
            end
            IRQ_EN_OFF: rdata[0] = irq_en_q;
            OP_OFF:     rdata = op_word;
            RM_OFF:     rdata[2:0] = rm_q;
            default:    rdata = '0;
        endcase
    end

    // Next-state for registers: software writes, then completion capture,
    // with the write winning valid_o and completion winning done.
    always_comb begin
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        result_d = result_q;
        flags_d  = flags_q;
        op_d     = op_q;
        valid_d  = valid_q;
        done_d   = done_q;
        irq_en_d = irq_en_q;
        rm_d     = rm_q;

        if (fpu_valid_i) begin
            result_d = fpu_result_i;
            flags_d  = fpu_flags_i;
            valid_d  = 1'b0;
        end

        if (wr) begin
            case (off)
                A_OFF:      a_d = merge_bytes(a_q, wbs_dat_i, wbs_sel_i);
                B_OFF:      b_d = merge_bytes(b_q, wbs_dat_i, wbs_sel_i);
                C_OFF:      c_d = merge_bytes(c_q, wbs_dat_i, wbs_sel_i);
                IRQ_EN_OFF: irq_en_d = wbs_dat_i[0];
                OP_OFF: begin
                    op_d = op_merge[OP_W-1:0];
                    // The valid bit lives in byte lane 1.
                    if (wbs_sel_i[1]) valid_d = op_merge[OP_VALID_BIT];
                end
                CLEAR_OFF:  if (wbs_dat_i[0]) done_d = 1'b0;
                RM_OFF:     rm_d = rm_merge[2:0];
                default:    ;
            endcase
        end

        if (fpu_valid_i) done_d = 1'b1;
    end

    // Bus response: one-cycle ack, read data only while ack is high.
    always_comb begin
        ack_d = req;
        dat_d = (req & ~wbs_we_i) ? rdata : 32'h0;
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge wb_clk_i or negedge rst_l) begin
        if (!rst_l) begin
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            op_q     <= '0;
            valid_q  <= 1'b0;
            done_q   <= 1'b0;
            irq_en_q <= 1'b0;
            rm_q     <= RM_RNE;
            ack_q    <= 1'b0;
            dat_q    <= '0;
        end else begin
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            op_q     <= op_d;
            valid_q  <= valid_d;
            done_q   <= done_d;
            irq_en_q <= irq_en_d;
            rm_q     <= rm_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
        end
    end

    assign wbs_ack_o    = ack_q;
    assign wbs_dat_o    = dat_q;
    assign a_o          = a_q;
    assign b_o          = b_q;
    assign c_o          = c_q;
    assign round_mode_o = rm_q;
    assign op_o         = op_q;
    assign valid_o      = valid_q;
    assign irq_o        = done_q & irq_en_q;

endmodule

// File: tb/tb_fpu_wb_regs.sv
// Bench for fpu_wb_regs: directed register-map scenarios followed by random
// bus traffic and FPU completions, checked against a register-level model.
module tb_fpu_wb_regs;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] adr, dat_i;
    logic        ack;
    logic [31:0] dat_o;
    logic [31:0] a_o, b_o, c_o;
    logic [2:0]  rm_o;
    logic [11:0] op_o;
    logic        valid_o;
    logic [31:0] fpu_res;
    logic [4:0]  fpu_flg;
    logic        fpu_vld;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    // Model state: register contents as software sees them.
    logic [31:0] m_a, m_b, m_c, m_res, m_op, m_rm;
    logic [4:0]  m_flg;
    logic        m_done, m_irqen;

    localparam logic [31:0] BASE = 32'h3000_0000;

    always #5 clk = ~clk;

    fpu_wb_regs dut (
        .wb_clk_i     (clk),
        .rst_l        (rst_l),
        .wbs_stb_i    (stb),
        .wbs_cyc_i    (cyc),
        .wbs_we_i     (we),
        .wbs_sel_i    (sel),
        .wbs_adr_i    (adr),
        .wbs_dat_i    (dat_i),
        .wbs_ack_o    (ack),
        .wbs_dat_o    (dat_o),
        .a_o          (a_o),
        .b_o          (b_o),
        .c_o          (c_o),
        .round_mode_o (rm_o),
        .op_o         (op_o),
        .valid_o      (valid_o),
        .fpu_result_i (fpu_res),
        .fpu_flags_i  (fpu_flg),
        .fpu_valid_i  (fpu_vld),
        .irq_o        (irq_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%08h expected=%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (s[i]) r[i*8 +: 8] = new_v[i*8 +: 8];
        return r;
    endfunction

    task automatic model_reset();
        m_a = 0; m_b = 0; m_c = 0; m_res = 0; m_op = 0; m_rm = 0;
        m_flg = 0; m_done = 0; m_irqen = 0;
    endtask

    function automatic logic [31:0] model_read(input logic [7:0] o);
        case (o)
            8'h00:   return m_a;
            8'h04:   return m_b;
            8'h08:   return m_c;
            8'h0C:   return m_res;
            8'h10:   return {27'b0, m_flg};
            8'h14:   return {30'b0, m_op[12], m_done};
            8'h18:   return {31'b0, m_irqen};
            8'h1C:   return m_op;
            8'h24:   return m_rm;
            default: return 32'h0;
        endcase
    endfunction

    // Completion of an FPU operation as software observes it.
    task automatic model_complete(input logic [31:0] r, input logic [4:0] f);
        m_res   = r;
        m_flg   = f;
        m_done  = 1'b1;
        m_op[12] = 1'b0;
    endtask

    task automatic model_write(input logic [7:0] o, input logic [31:0] d, input logic [3:0] s,
                               input logic fire);
        case (o)
            8'h00: m_a = merge(m_a, d, s);
            8'h04: m_b = merge(m_b, d, s);
            8'h08: m_c = merge(m_c, d, s);
            8'h18: m_irqen = d[0];
            8'h1C: m_op = merge(m_op, d, s) & 32'h0000_1FFF;
            8'h20: if (d[0] && !fire) m_done = 1'b0;
            8'h24: m_rm = merge(m_rm, d, s) & 32'h0000_0007;
            default: ;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".a_o"},     a_o, m_a);
        check({tag, ".b_o"},     b_o, m_b);
        check({tag, ".c_o"},     c_o, m_c);
        check({tag, ".op_o"},    {20'b0, op_o}, {20'b0, m_op[11:0]});
        check({tag, ".valid_o"}, {31'b0, valid_o}, {31'b0, m_op[12]});
        check({tag, ".rm_o"},    {29'b0, rm_o}, m_rm);
        check({tag, ".irq_o"},   {31'b0, irq_o}, {31'b0, m_done & m_irqen});
    endtask

    // One bus transaction, optionally with an FPU completion in the same cycle.
    task automatic bus(input string tag, input logic [31:0] a, input logic w,
                       input logic [31:0] d, input logic [3:0] s,
                       input logic fire, input logic [31:0] fr, input logic [4:0] ff);
        logic        is_hit;
        logic        got;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        int          n;
        is_hit = (a[31:8] == BASE[31:8]);
        exp_rd = model_read({a[7:2], 2'b00});
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat_i = d; sel = s;
        if (fire) begin fpu_vld = 1; fpu_res = fr; fpu_flg = ff; end
        n = 0; got = 0; rd = 0;
        while (n < 4 && !got) begin
            @(posedge clk); #1;
            n++;
            if (n == 1) fpu_vld = 0;
            if (ack) begin got = 1; rd = dat_o; end
        end
        cyc = 0; stb = 0; we = 0;
        if (fire) model_complete(fr, ff);
        if (is_hit) begin
            check({tag, ".ack_lat"}, n, 1);
            if (w) model_write({a[7:2], 2'b00}, d, s, fire);
            else check({tag, ".rdata"}, rd, exp_rd);
            @(posedge clk); #1;
            check({tag, ".ack_drop"}, {31'b0, ack}, 32'h0);
            check({tag, ".dat_idle"}, dat_o, 32'h0);
        end else begin
            check({tag, ".miss_noack"}, {31'b0, got}, 32'h0);
        end
    endtask

    task automatic wr(input string tag, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        bus(tag, a, 1'b1, d, s, 1'b0, 32'h0, 5'h0);
    endtask

    task automatic rd(input string tag, input logic [31:0] a);
        bus(tag, a, 1'b0, 32'h0, 4'hF, 1'b0, 32'h0, 5'h0);
    endtask

    task automatic fpu_pulse(input logic [31:0] r, input logic [4:0] f);
        @(posedge clk); #1;
        fpu_vld = 1; fpu_res = r; fpu_flg = f;
        @(posedge clk); #1;
        fpu_vld = 0;
        model_complete(r, f);
    endtask

    initial begin
        logic [31:0] ra, rdat;
        logic [3:0]  rsel;
        logic        rwe, rfire;

        rst_l = 0; stb = 0; cyc = 0; we = 0; sel = 0; adr = 0; dat_i = 0;
        fpu_res = 0; fpu_flg = 0; fpu_vld = 0;
        model_reset();
        #2;
        check_outputs("reset");
        check("reset.ack", {31'b0, ack}, 32'h0);
        check("reset.dat", dat_o, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_l = 1;

        // Operand write and readback.
        wr("wr_a", BASE + 32'h00, 32'h4049_0FDB, 4'hF);
        check("wr_a.a_o", a_o, 32'h4049_0FDB);
        rd("rd_a", BASE + 32'h00);

        // Rounding mode: legal value, then all ones truncated to 3 bits.
        wr("wr_rm1", BASE + 32'h24, 32'h0000_0001, 4'hF);
        check("rm1.rm_o", {29'b0, rm_o}, 32'h1);
        rd("rd_rm1", BASE + 32'h24);
        wr("wr_rm7", BASE + 32'h24, 32'hFFFF_FFFF, 4'hF);
        check("rm7.rm_o", {29'b0, rm_o}, 32'h7);
        rd("rd_rm7", BASE + 32'h24);

        // Operation request.
        wr("wr_op", BASE + 32'h1C, 32'h0000_1004, 4'hF);
        check("op.op_o", {20'b0, op_o}, 32'h004);
        check("op.valid_o", {31'b0, valid_o}, 32'h1);
        rd("rd_op", BASE + 32'h1C);

        // Completion capture, interrupt, clear.
        fpu_pulse(32'h0000_0003, 5'b00001);
        check("cmp.valid_o", {31'b0, valid_o}, 32'h0);
        rd("rd_res", BASE + 32'h0C);
        rd("rd_flags", BASE + 32'h10);
        rd("rd_status", BASE + 32'h14);
        rd("rd_op_after", BASE + 32'h1C);
        check("rd_op_after.model", m_op, 32'h0000_0004);
        wr("wr_irqen", BASE + 32'h18, 32'h1, 4'hF);
        check("irq.set", {31'b0, irq_o}, 32'h1);
        wr("wr_clear", BASE + 32'h20, 32'h1, 4'hF);
        check("irq.clear", {31'b0, irq_o}, 32'h0);

        // Byte lanes and unmapped offsets.
        wr("wr_a0", BASE + 32'h00, 32'h0, 4'hF);
        wr("wr_a_lane1", BASE + 32'h00, 32'hFFFF_FFFF, 4'b0010);
        check("lane1.a_o", a_o, 32'h0000_FF00);
        rd("rd_a_lane1", BASE + 32'h00);
        rd("rd_unmapped", BASE + 32'h28);
        rd("rd_miss", 32'h3000_0100);

        // Same-cycle collisions: software wins valid_o, completion wins done.
        bus("col_op", BASE + 32'h1C, 1'b1, 32'h0000_1002, 4'hF, 1'b1, 32'h1234_5678, 5'b10100);
        check("col_op.valid_o", {31'b0, valid_o}, 32'h1);
        check("col_op.irq_o", {31'b0, irq_o}, 32'h1);
        bus("col_clr", BASE + 32'h20, 1'b1, 32'h1, 4'hF, 1'b1, 32'h0BAD_F00D, 5'b00010);
        check("col_clr.irq_o", {31'b0, irq_o}, 32'h1);
        rd("col_res", BASE + 32'h0C);
        check_outputs("collide");

        // Random traffic.
        for (int i = 0; i < 150; i++) begin
            ra = BASE + 32'($urandom_range(0, 11) * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) ra = ra + 32'h100;
            rwe   = 1'($urandom_range(0, 1));
            rdat  = $urandom;
            rsel  = 4'($urandom_range(0, 15));
            rfire = ($urandom_range(0, 4) == 0);
            bus("rand", ra, rwe, rdat, rsel, rfire, $urandom, 5'($urandom_range(0, 31)));
            check_outputs("rand");
        end

        // Reset in the ack cycle of a write.
        wr("pre_rst_irq", BASE + 32'h18, 32'h1, 4'hF);
        fpu_pulse(32'hCAFE_0001, 5'b11111);
        wr("pre_rst_op", BASE + 32'h1C, 32'h0000_1001, 4'hF);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 1; adr = BASE; dat_i = 32'h1234_ABCD; sel = 4'hF;
        @(posedge clk); #1;
        check("rst.ack_before", {31'b0, ack}, 32'h1);
        rst_l = 0;
        #1;
        model_reset();
        check("rst.ack", {31'b0, ack}, 32'h0);
        check("rst.dat", dat_o, 32'h0);
        check_outputs("rst");
        cyc = 0; stb = 0; we = 0;
        @(negedge clk) rst_l = 1;
        rd("rst.rd_a", BASE + 32'h00);
        rd("rst.rd_status", BASE + 32'h14);
        check_outputs("post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fpu_wb_regs.md
Name: fpu_wb_regs

Overview:
- Wishbone slave register bank inside the user project area that fronts the single-precision FPU core.
- Software on the management SoC writes operands, rounding mode and the operation word. The block drives these to the FPU core and captures the result and exception flags when the core signals completion.
- Fits between the Caravel Wishbone bus (user space at 0x3000_0000) and the FPU datapath. The FPU core itself is external to this block.

Parameters:
- BASE_ADDR, 32'h3000_0000, base address of the register window; decode matches wbs_adr_i[31:8] against BASE_ADDR[31:8].
- OP_W, 12, width of the one-hot operation field op_o.

Ports:
- wb_clk_i  in  1  single clock for the bus and all registers.
- rst_l  in  1  asynchronous, active-low reset.
- wbs_stb_i  in  1  Wishbone strobe.
- wbs_cyc_i  in  1  Wishbone cycle.
- wbs_we_i  in  1  1 = write.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_ack_o  out  1  transfer acknowledge.
- wbs_dat_o  out  32  read data.
- a_o, b_o, c_o  out  32 each  operands to the FPU.
- round_mode_o  out  3  IEEE rounding mode.
- op_o  out  12  operation select.
- valid_o  out  1  operation request to the FPU.
- fpu_result_i  in  32  FPU result.
- fpu_flags_i  in  5  exception flags {NV,DZ,OF,UF,NX}.
- fpu_valid_i  in  1  one-cycle result-valid pulse.
- irq_o  out  1  completion interrupt.

Behaviour:
- Register map (offset from BASE_ADDR; word aligned, wbs_adr_i[1:0] ignored):
  - 0x00 A: RW, a_o.
  - 0x04 B: RW, b_o.
  - 0x08 C: RW, c_o.
  - 0x0C RESULT: RO, captured fpu_result_i.
  - 0x10 FLAGS: RO, bits[4:0] captured fpu_flags_i.
  - 0x14 STATUS: bit0 done (RO), bit1 busy = valid_o (RO).
  - 0x18 IRQ_EN: RW, bit0.
  - 0x1C OPERATION: RW, bits[11:0] op_o, bit12 valid_o, bits[31:13] read as 0.
  - 0x20 CLEAR: WO, writing bit0 = 1 clears done.
  - 0x24 ROUND_MODE: RW, bits[2:0] round_mode_o, upper bits read 0.
  - Unmapped offsets: writes ignored, reads return 0, still acknowledged.
- Wishbone handshake:
  - Request = wbs_cyc_i & wbs_stb_i & address hit & ~wbs_ack_o.
  - wbs_ack_o pulses high for exactly one cycle, the cycle after the request is sampled. Back-to-back requests are therefore separated by at least one idle ack-low cycle.
  - Writes take effect on the same clock edge that raises ack. Registered outputs show the new value one cycle after the request is sampled, and hold it until the next write.
  - Byte lanes are honoured for A, B, C, OPERATION and ROUND_MODE.
  - wbs_dat_o is registered and valid while ack is high; it is 0 otherwise.
  - Requests outside BASE_ADDR[31:8] are never acknowledged.
- Completion:
  - On fpu_valid_i: RESULT <= fpu_result_i, FLAGS <= fpu_flags_i, done <= 1, valid_o <= 0. Other OPERATION bits are retained.
  - If a software write to OPERATION occurs in the same cycle as fpu_valid_i, the software write wins for valid_o.
  - A CLEAR write in the same cycle as fpu_valid_i leaves done = 1 (set wins).
- valid_o stays high from the OPERATION write until fpu_valid_i or a software write of bit12 = 0. It is level, not a pulse.
- irq_o = done & IRQ_EN[0], combinational from registers.
- Reset (async, rst_l low): all registers, wbs_ack_o, wbs_dat_o, valid_o, done and irq_o go to 0; round_mode_o = 0 (RNE). Reset asserted mid-transaction drops ack immediately, and no partial write is retained.

Decomposition:
- Shared package fpu_pkg holds:
  - register offset constants (A_OFF … RM_OFF);
  - rounding-mode encodings RNE = 0, RTZ = 1, RDN = 2, RUP = 3, RMM = 4;
  - one-hot op_o bit positions (e.g. bit for float-to-int conversion);
  - the flag-bit order.
- No sub-module is needed. Address decode, the register file and completion capture live in one module.

Test Plan:
- Write 0x3000_0000 = 0x4049_0FDB -> ack one cycle later; a_o == 0x4049_0FDB two clock edges after the request; read back returns the same value.
- Write 0x3000_0024 = 0x0000_0001 -> round_mode_o == 3'b001; read returns 0x0000_0001. Write 0xFFFF_FFFF -> round_mode_o = 3'b111 and reads back 0x0000_0007.
- Write 0x3000_001C = 0x0000_1004 -> op_o == 12'h004, valid_o == 1 two edges later; read returns 0x0000_1004.
- With valid_o high, pulse fpu_valid_i with result 0x0000_0003 and flags 5'b00001 -> RESULT = 0x3, FLAGS = 0x1, done = 1, valid_o = 0, OPERATION reads 0x0000_0004. With IRQ_EN = 1, irq_o = 1; a CLEAR write drops irq_o.
- Write A = 0xFFFF_FFFF with wbs_sel_i = 4'b0010 after A = 0 -> A reads 0x0000_FF00. Read offset 0x28 -> ack with data 0.
- Assert rst_l low during a write's ack cycle -> ack and all outputs go to 0 immediately; the write is not retained after reset release.
